// File: rtl/const_ext_pkg.sv
// const_ext_pkg
// Shared definitions for the constant-extension unit: the request mode
// encodings and the prefix state machine encoding.
package const_ext_pkg;

    // Request modes carried on the 2-bit mode input
    localparam logic [1:0] MODE_ZERO   = 2'd0;
    localparam logic [1:0] MODE_SIGN   = 2'd1;
    localparam logic [1:0] MODE_UPPER  = 2'd2;
    localparam logic [1:0] MODE_PREFIX = 2'd3;

    // Prefix state machine: PFX means a prefix is captured and unused
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PFX  = 1'b1
    } pfx_state_e;

endpackage : const_ext_pkg

// File: rtl/const_ext_core.sv
// const_ext_core
// Purely combinational extension datapath.
//   mode_i     : request mode (ZERO / SIGN / UPPER / PREFIX)
//   im_i       : immediate field
//   prefix_i   : currently stored prefix
//   pending_i  : a stored prefix is waiting to be merged
//   value_o    : extended constant for ZERO / SIGN / UPPER
//   pfx_sx_o   : im_i sign-extended (or truncated) to the prefix width,
//                the value a PREFIX request loads into the prefix register
module const_ext_core
    import const_ext_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 15
) (
    input  logic [1:0]              mode_i,
    input  logic [IMM_W-1:0]        im_i,
    input  logic [DATA_W-IMM_W-1:0] prefix_i,
    input  logic                    pending_i,
    output logic [DATA_W-1:0]       value_o,
    output logic [DATA_W-IMM_W-1:0] pfx_sx_o
);

    localparam int PFX_W = DATA_W - IMM_W;

    // Prefix load value: widen with the sign bit, or keep the low bits when
    // the prefix field is no wider than the immediate.
    generate
        if (PFX_W > IMM_W) begin : g_pfx_widen
            assign pfx_sx_o = {{(PFX_W - IMM_W){im_i[IMM_W-1]}}, im_i};
        end else begin : g_pfx_trunc
            assign pfx_sx_o = im_i[PFX_W-1:0];
        end
    endgenerate

    // Extension mux; a pending prefix replaces the fill bits of ZERO/SIGN
    always_comb begin
        value_o = '0;
        case (mode_i)
            MODE_ZERO: begin
                if (pending_i) begin
                    value_o = {prefix_i, im_i};
                end else begin
                    value_o = {{PFX_W{1'b0}}, im_i};
                end
            end
            MODE_SIGN: begin
                if (pending_i) begin
                    value_o = {prefix_i, im_i};
                end else begin
                    value_o = {{PFX_W{im_i[IMM_W-1]}}, im_i};
                end
            end
            MODE_UPPER: begin
                // IMM_W + PFX_W == DATA_W, so this is exactly im << PFX_W
                value_o = {im_i, {PFX_W{1'b0}}};
            end
            MODE_PREFIX: begin
                // PREFIX never produces an output word
                value_o = '0;
            end
            default: begin
                value_o = '0;
            end
        endcase
    end

endmodule : const_ext_core

// File: rtl/const_ext_unit.sv
// const_ext_unit
// One-deep registered constant-extension stage with a prefix register.
//   clk, rst_n  : clock, asynchronous active-low reset
//   in_valid/in_ready, im, mode : request handshake and payload
//   flush       : synchronous discard of pending prefix, output and error
//   out_valid/out_ready, cuo    : result handshake and extended constant
//   pfx_pending : prefix captured and not yet consumed
//   pfx_err     : sticky, an UPPER request dropped a pending prefix
module const_ext_unit
    import const_ext_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IMM_W-1:0]  im,
    input  logic [1:0]        mode,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] cuo,
    output logic              pfx_pending,
    output logic              pfx_err
);

    localparam int PFX_W = DATA_W - IMM_W;

    pfx_state_e        state_q,     state_d;
    logic [PFX_W-1:0]  prefix_q,    prefix_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] cuo_q,       cuo_d;
    logic              pfx_err_q,   pfx_err_d;

    logic              accept_s;
    logic              consume_s;
    logic              pending_s;
    logic [DATA_W-1:0] value_s;
    logic [PFX_W-1:0]  pfx_sx_s;

    assign pending_s = (state_q == ST_PFX);

    // flush forces in_ready high so the producer never stalls on a flush
    assign in_ready  = flush | ~out_valid_q | out_ready;
    assign accept_s  = in_valid & in_ready & ~flush;
    assign consume_s = out_valid_q & out_ready;

    const_ext_core #(
        .DATA_W (DATA_W),
        .IMM_W  (IMM_W)
    ) u_core (
        .mode_i    (mode),
        .im_i      (im),
        .prefix_i  (prefix_q),
        .pending_i (pending_s),
        .value_o   (value_s),
        .pfx_sx_o  (pfx_sx_s)
    );

    // Next-state: flush wins, then an accepted request, else drain on consume
    always_comb begin
        state_d     = state_q;
        prefix_d    = prefix_q;
        out_valid_d = out_valid_q;
        cuo_d       = cuo_q;
        pfx_err_d   = pfx_err_q;
        if (flush) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            pfx_err_d   = 1'b0;
        end else if (accept_s) begin
            if (mode == MODE_PREFIX) begin
                prefix_d    = pfx_sx_s;
                state_d     = ST_PFX;
                // no new word: the output only drains if taken this cycle
                out_valid_d = out_valid_q & ~consume_s;
            end else begin
                cuo_d       = value_s;
                out_valid_d = 1'b1;
                state_d     = ST_IDLE;
                if ((mode == MODE_UPPER) && pending_s) begin
                    pfx_err_d = 1'b1;
                end else begin
                    pfx_err_d = pfx_err_q;
                end
            end
        end else begin
            out_valid_d = out_valid_q & ~consume_s;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            prefix_q    <= '0;
            out_valid_q <= 1'b0;
            cuo_q       <= '0;
            pfx_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            prefix_q    <= prefix_d;
            out_valid_q <= out_valid_d;
            cuo_q       <= cuo_d;
            pfx_err_q   <= pfx_err_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign cuo         = cuo_q;
    assign pfx_pending = pending_s;
    assign pfx_err     = pfx_err_q;

endmodule : const_ext_unit

// File: tb/tb_const_ext_unit.sv
// Self-checking bench for const_ext_unit (DATA_W=32, IMM_W=15).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_const_ext_unit;
    import const_ext_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [14:0] im;
    logic [1:0]  mode;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] cuo;
    logic        pfx_pending;
    logic        pfx_err;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    logic [31:0] sb_q[$];
    logic        mdl_pending = 1'b0;
    logic [16:0] mdl_prefix  = 17'd0;
    logic        mdl_err     = 1'b0;
    logic [31:0] exp_v;

    typedef struct {
        logic [1:0]  m;
        logic [14:0] v;
    } req_t;

    const_ext_unit #(.DATA_W(32), .IMM_W(15)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .im          (im),
        .mode        (mode),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .cuo         (cuo),
        .pfx_pending (pfx_pending),
        .pfx_err     (pfx_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model_ext(input logic [1:0] m, input logic [14:0] v);
        logic [31:0] r;
        if (m == MODE_UPPER)              r = 32'(v) << 17;
        else if (mdl_pending)             r = (32'(mdl_prefix) << 15) | 32'(v);
        else if (m == MODE_SIGN)          r = 32'($signed(v));
        else                              r = 32'(v);
        return r;
    endfunction

    // update model for a request the DUT is about to accept
    task automatic accept_model(input logic [1:0] m, input logic [14:0] v);
        if (m == MODE_PREFIX) begin
            mdl_prefix  = 17'($signed(v));
            mdl_pending = 1'b1;
        end else begin
            sb_q.push_back(model_ext(m, v));
            if (m == MODE_UPPER && mdl_pending) mdl_err = 1'b1;
            mdl_pending = 1'b0;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [1:0] m, input logic [14:0] v);
        mode = m; im = v; in_valid = 1'b1;
        accept_model(m, v);
        cycle();
        in_valid = 1'b0;
    endtask

    task automatic model_reset();
        sb_q.delete();
        mdl_pending = 1'b0;
        mdl_prefix  = 17'd0;
        mdl_err     = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if ({out_valid, cuo, pfx_pending, pfx_err} !== 35'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got ov=%b cuo=%h pp=%b pe=%b, want all 0", out_valid, cuo, pfx_pending, pfx_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_basic();
        req_t tab[8];
        tab = '{'{MODE_SIGN, 15'h4000}, '{MODE_ZERO, 15'h7FFF}, '{MODE_UPPER, 15'h0001},
                '{MODE_SIGN, 15'h3FFF}, '{MODE_UPPER, 15'h7FFF}, '{MODE_ZERO, 15'h4000},
                '{MODE_SIGN, 15'(($urandom))}, '{MODE_UPPER, 15'(($urandom))}};
        for (int i = 0; i < 8; i++) begin
            drive(tab[i].m, tab[i].v);
            exp_v = sb_q.pop_front();
            n_cmp++;
            if (out_valid !== 1'b1 || cuo !== exp_v) begin
                n_bad++;
                $display("FAIL basic[%0d]: got ov=%b cuo=%h want ov=1 cuo=%h", i, out_valid, cuo, exp_v);
            end
            if (i == 0) begin
                n_cmp++;
                if (cuo !== 32'hFFFF_C000) begin
                    n_bad++;
                    $display("FAIL sign_4000: got %h want ffffc000", cuo);
                end
            end
        end
        cycle();
        n_cmp++;
        if (out_valid !== 1'b0 || pfx_pending !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_drain: got ov=%b pp=%b want 0 0", out_valid, pfx_pending);
        end
    endtask

    task automatic test_prefix();
        drive(MODE_PREFIX, 15'h1234);
        n_cmp++;
        if (pfx_pending !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL prefix_pending: got pp=%b ov=%b want 1 0", pfx_pending, out_valid);
        end
        drive(MODE_ZERO, 15'h0ABC);
        exp_v = sb_q.pop_front();
        n_cmp++;
        if (cuo !== exp_v || out_valid !== 1'b1 || pfx_pending !== 1'b0 || cuo !== 32'h091A_0ABC) begin
            n_bad++;
            $display("FAIL prefix_zero: got cuo=%h ov=%b pp=%b want cuo=%h ov=1 pp=0", cuo, out_valid, pfx_pending, exp_v);
        end
        // overwrite a pending prefix with a negative one, then merge via SIGN
        drive(MODE_PREFIX, 15'h0001);
        drive(MODE_PREFIX, 15'h4000);
        drive(MODE_SIGN, 15'h0005);
        exp_v = sb_q.pop_front();
        n_cmp++;
        if (cuo !== exp_v || pfx_pending !== 1'b0) begin
            n_bad++;
            $display("FAIL prefix_overwrite: got cuo=%h pp=%b want cuo=%h pp=0", cuo, pfx_pending, exp_v);
        end
        cycle();
    endtask

    task automatic test_upper_err();
        drive(MODE_PREFIX, 15'h7FFF);
        drive(MODE_UPPER, 15'h0003);
        exp_v = sb_q.pop_front();
        n_cmp++;
        if (cuo !== exp_v || pfx_err !== mdl_err || pfx_err !== 1'b1 || pfx_pending !== 1'b0) begin
            n_bad++;
            $display("FAIL upper_err: got cuo=%h pe=%b pp=%b want cuo=%h pe=1 pp=0", cuo, pfx_err, pfx_pending, exp_v);
        end
        drive(MODE_ZERO, 15'h0042);
        exp_v = sb_q.pop_front();
        n_cmp++;
        if (cuo !== exp_v || pfx_err !== 1'b1) begin
            n_bad++;
            $display("FAIL err_sticky: got cuo=%h pe=%b want cuo=%h pe=1", cuo, pfx_err, exp_v);
        end
        // flush with a competing request: request dropped, flags cleared
        out_ready = 1'b0;
        flush = 1'b1; in_valid = 1'b1; mode = MODE_ZERO; im = 15'h0111;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL flush_in_ready: got %b want 1", in_ready);
        end
        cycle();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        mdl_err = 1'b0; mdl_pending = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || pfx_err !== mdl_err || pfx_pending !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_clear: got ov=%b pe=%b pp=%b want 0 0 0", out_valid, pfx_err, pfx_pending);
        end
        cycle();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_no_accept: got ov=%b want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        req_t rq[4];
        logic [31:0] held;
        rq = '{'{MODE_SIGN, 15'h7001}, '{MODE_UPPER, 15'h1234}, '{MODE_ZERO, 15'h0F0F}, '{MODE_SIGN, 15'h0123}};
        out_ready = 1'b0;
        drive(MODE_ZERO, 15'h2AAA);
        held = sb_q[0];
        // keep the next request offered while the output is stalled
        mode = rq[0].m; im = rq[0].v; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_cmp++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || cuo !== held) begin
                n_bad++;
                $display("FAIL stall[%0d]: got ir=%b ov=%b cuo=%h want ir=0 ov=1 cuo=%h", k, in_ready, out_valid, cuo, held);
            end
            cycle();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mode = rq[i].m; im = rq[i].v; in_valid = 1'b1;
            exp_v = sb_q.pop_front();
            n_cmp++;
            if (out_valid !== 1'b1 || cuo !== exp_v) begin
                n_bad++;
                $display("FAIL b2b[%0d]: got ov=%b cuo=%h want ov=1 cuo=%h", i, out_valid, cuo, exp_v);
            end
            accept_model(rq[i].m, rq[i].v);
            cycle();
        end
        in_valid = 1'b0;
        exp_v = sb_q.pop_front();
        n_cmp++;
        if (out_valid !== 1'b1 || cuo !== exp_v) begin
            n_bad++;
            $display("FAIL b2b_last: got ov=%b cuo=%h want ov=1 cuo=%h", out_valid, cuo, exp_v);
        end
        cycle();
        n_cmp++;
        if (out_valid !== 1'b0 || sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL b2b_drain: got ov=%b left=%0d want 0 0", out_valid, sb_q.size());
        end
    endtask

    task automatic test_async_reset();
        // stalled output with sticky error
        drive(MODE_PREFIX, 15'h0007);
        out_ready = 1'b0;
        drive(MODE_UPPER, 15'h0009);
        cycle();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, cuo, pfx_pending, pfx_err} !== 35'd0) begin
            n_bad++;
            $display("FAIL async_rst_stall: got ov=%b cuo=%h pp=%b pe=%b want all 0", out_valid, cuo, pfx_pending, pfx_err);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        cycle();
        // prefix pending when reset hits
        drive(MODE_PREFIX, 15'h5555);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (pfx_pending !== 1'b0 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL async_rst_pfx: got pp=%b ov=%b want 0 0", pfx_pending, out_valid);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        drive(MODE_ZERO, 15'h0321);
        exp_v = sb_q.pop_front();
        n_cmp++;
        if (cuo !== exp_v || out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL post_rst_idle: got cuo=%h ov=%b want cuo=%h ov=1", cuo, out_valid, exp_v);
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; im = 15'd0; mode = MODE_ZERO;
        flush = 1'b0; out_ready = 1'b1;
        test_reset();
        test_basic();
        test_prefix();
        test_upper_err();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_const_ext_unit
